// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access sizes, FSM states, default width.
package mem_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    // funct3 size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port.
//   master (mem_stage): drives dmem_req/we/addr/wdata/be, receives dmem_ack/rdata
//   slave  (memory)   : receives the request, returns dmem_ack with dmem_rdata
interface mem_stage_if #(
    parameter int unsigned DATA_W = mem_pkg::DATA_W_DEFAULT
) ();
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads (purely combinational).
//   funct3     : access size/sign
//   addr_lo    : low two address bits
//   store_data : rs2 value
//   rdata      : word read from memory
//   be/wdata   : store byte enables and lane-replicated data
//   load_data  : extracted, extended load result
//   misaligned : halfword on odd address or word on non-word address
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);
    logic [31:0] shifted;

    // Bring the addressed byte/half down to bit 0
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'h0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                misaligned = addr_lo[0];
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'h0, shifted[15:0]};
            end
            // Word and any unlisted encoding
            default: misaligned = |addr_lo;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack port, stalls upstream
// while an access is outstanding, aborts after TIMEOUT_CYCLES, and registers the
// write-back bundle.
//   clk, rst              : clock, async active-high reset
//   valid_in..reg_write_in: EX/MEM inputs
//   stall_out             : combinational hold request to upstream
//   dmem                  : data-memory port (master)
//   wb_*                  : registered write-back bundle, wb_valid is a 1-cycle pulse
//   misalign_fault        : 1-cycle pulse on misalignment or timeout
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned DATA_W         = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd_in,
    input  logic              reg_write_in,
    output logic              stall_out,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_reg_write,
    output logic              misalign_fault
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic [4:0]        rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              wb_valid_d, wb_rw_d, fault_d;
    logic [4:0]        wb_rd_d;
    logic [DATA_W-1:0] wb_data_d;
    logic              stall_c;

    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        al_mis;

    // Alignment unit sees live inputs at accept time, captured ones during ACCESS
    assign al_f3 = (state_q == ACCESS) ? f3_q : funct3;
    assign al_lo = (state_q == ACCESS) ? lo_q : ALU_result[1:0];

    lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .store_data (store_data),
        .rdata      (dmem.dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd;
        wb_data_d  = wb_data;
        wb_rw_d    = wb_reg_write;
        fault_d    = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    wb_rd_d = rd_in;
                    if (!(mem_read || mem_write)) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ALU_result;
                        wb_rw_d    = reg_write_in;
                    end else if (al_mis) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        wb_rw_d    = 1'b0;
                        fault_d    = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = ACCESS;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {ALU_result[DATA_W-1:2], 2'b00};
                        wdata_d = al_wdata;
                        be_d    = al_be;
                        f3_d    = funct3;
                        lo_d    = ALU_result[1:0];
                        rd_d    = rd_in;
                        rw_d    = reg_write_in && !mem_write;
                    end
                end
            end
            ACCESS: begin
                wb_rd_d = rd_q;
                if (dmem.dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rw_d    = rw_q;
                    wb_data_d  = we_q ? '0 : al_load;
                end else if (cnt_q == CNT_LAST) begin
                    // Release upstream now; the fault bundle appears next cycle
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rw_d    = 1'b0;
                    wb_data_d  = '0;
                    fault_d    = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            f3_q           <= '0;
            lo_q           <= '0;
            rd_q           <= '0;
            rw_q           <= 1'b0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            wb_reg_write   <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            f3_q           <= f3_d;
            lo_q           <= lo_d;
            rd_q           <= rd_d;
            rw_q           <= rw_d;
            wb_valid       <= wb_valid_d;
            wb_rd          <= wb_rd_d;
            wb_data        <= wb_data_d;
            wb_reg_write   <= wb_rw_d;
            misalign_fault <= fault_d;
        end
    end

    // Stall is combinational; gated so it falls with reset regardless of valid_in
    assign stall_out = stall_c && !rst;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
endmodule
